// File: rtl/adxl345_pkg.sv
// Shared register map, reset values, command layout and FSM states for the ADXL345 SPI slave model.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adxl345_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] DEVID_RST       = 8'hE5;
    localparam logic [7:0] BW_RATE_RST     = 8'h0A;
    localparam logic [7:0] POWER_CTL_RST   = 8'h00;
    localparam logic [7:0] DATA_FORMAT_RST = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // First byte of every transfer, MSB first on the wire.
    typedef struct packed {
        logic       rd;
        logic       mb;
        logic [5:0] addr;
    } cmd_t;

    function automatic logic is_read_only(input logic [5:0] addr);
        return (addr == ADDR_DEVID) || ((addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1));
    endfunction

    function automatic logic [7:0] reg_reset_value(input logic [5:0] addr, input logic [7:0] devid);
        logic [7:0] val;
        case (addr)
            ADDR_DEVID:       val = devid;
            ADDR_BW_RATE:     val = BW_RATE_RST;
            ADDR_POWER_CTL:   val = POWER_CTL_RST;
            ADDR_DATA_FORMAT: val = DATA_FORMAT_RST;
            default:          val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes spi_clk, CS and MOSI into clk and flags spi_clk edges and the CS falling edge.
// Latency: SYNC_STAGES clk cycles from pin to synchronized level/edge strobe.
// Backpressure: none; edges are single-cycle strobes that must be consumed when seen.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic cs_pin_n,
    input  logic mosi_pin,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n,
    output logic cs_fall,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sclk_prev;
    logic                   cs_prev;

    // CS resets to "selected" so that a CS already low at reset release
    // produces no falling edge; a genuine high-then-low is required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff   <= '1;
            cs_ff     <= '0;
            mosi_ff   <= '0;
            sclk_prev <= 1'b1;
            cs_prev   <= 1'b0;
        end else begin
            sclk_ff[0] <= spi_clk;
            cs_ff[0]   <= cs_pin_n;
            mosi_ff[0] <= mosi_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_ff[i] <= sclk_ff[i-1];
                cs_ff[i]   <= cs_ff[i-1];
                mosi_ff[i] <= mosi_ff[i-1];
            end
            sclk_prev <= sclk_ff[SYNC_STAGES-1];
            cs_prev   <= cs_ff[SYNC_STAGES-1];
        end
    end

    always_comb begin
        cs_n      = cs_ff[SYNC_STAGES-1];
        mosi      = mosi_ff[SYNC_STAGES-1];
        sclk_rise = sclk_ff[SYNC_STAGES-1] & ~sclk_prev;
        sclk_fall = ~sclk_ff[SYNC_STAGES-1] & sclk_prev;
        cs_fall   = cs_prev & ~cs_ff[SYNC_STAGES-1];
    end

endmodule

// File: rtl/adxl345_spi_slave.sv
// ADXL345-style SPI mode-3 register slave; ADXL345_SLAVE_SNAPSHOT_EN makes axis-data updates wait for IDLE.
// Latency: MISO bit valid SYNC_STAGES+1 clk after each spi_clk fall; writes commit on a byte's 8th rise.
// Backpressure: none; the SPI master paces everything and clk must run at least 8x spi_clk.
module adxl345_spi_slave
    import adxl345_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_VALUE = DEVID_RST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        miso_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        reg_wr_strobe,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic [7:0]  bw_rate,
    output logic [7:0]  power_ctl,
    output logic [7:0]  data_format
);

    logic        sclk_rise;
    logic        sclk_fall;
    logic        cs_n_s;
    logic        cs_fall;
    logic        mosi_s;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  shift_out;
    logic        miso_q;
    cmd_t        cmd;
    logic [7:0]  regs [64];

    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        cmd_done;
    logic        data_done;
    logic        wr_commit;
    logic [5:0]  next_addr;

    logic        load_samples;
    logic [15:0] ld_x;
    logic [15:0] ld_y;
    logic [15:0] ld_z;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .cs_pin_n  (CS),
        .mosi_pin  (MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_n      (cs_n_s),
        .cs_fall   (cs_fall),
        .mosi      (mosi_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                if (cs_n_s) begin
                    state_nxt = ST_IDLE;
                end else if (cmd_done) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: if (cs_n_s) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_byte   = {shift_in, mosi_s};
        byte_done = sclk_rise && !cs_n_s && (bit_cnt == 3'd7);
        cmd_done  = byte_done && (state == ST_CMD);
        data_done = byte_done && (state == ST_DATA);
        wr_commit = data_done && !cmd.rd && !is_read_only(cmd.addr);
        next_addr = cmd.mb ? (cmd.addr + 6'd1) : cmd.addr;
        miso_oe   = (state == ST_DATA) && cmd.rd && !cs_n_s;
        MISO      = miso_oe ? miso_q : 1'b1;
    end

    // Deselect at any point drops the partial byte and rearms the bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            miso_q    <= 1'b1;
            cmd       <= '0;
        end else if ((state == ST_IDLE) || cs_n_s) begin
            bit_cnt <= '0;
            miso_q  <= 1'b1;
        end else begin
            if (sclk_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= rx_byte[6:0];
            end
            if (cmd_done) begin
                cmd       <= cmd_t'(rx_byte);
                shift_out <= regs[rx_byte[5:0]];
            end else if (data_done) begin
                cmd.addr  <= next_addr;
                shift_out <= regs[next_addr];
            end else if (sclk_fall && (state == ST_DATA)) begin
                miso_q    <= shift_out[7];
                shift_out <= {shift_out[6:0], 1'b0};
            end
        end
    end

`ifdef ADXL345_SLAVE_SNAPSHOT_EN
    logic [15:0] snap_x;
    logic [15:0] snap_y;
    logic [15:0] snap_z;
    logic        snap_pend;

    // Samples park here during a transfer so a burst never mixes two sample sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_x    <= '0;
            snap_y    <= '0;
            snap_z    <= '0;
            snap_pend <= 1'b0;
        end else if (sample_valid) begin
            snap_x    <= sample_x;
            snap_y    <= sample_y;
            snap_z    <= sample_z;
            snap_pend <= 1'b1;
        end else if (state == ST_IDLE) begin
            snap_pend <= 1'b0;
        end
    end

    always_comb begin
        load_samples = snap_pend && (state == ST_IDLE);
        ld_x         = snap_x;
        ld_y         = snap_y;
        ld_z         = snap_z;
    end
`else
    always_comb begin
        load_samples = sample_valid;
        ld_x         = sample_x;
        ld_y         = sample_y;
        ld_z         = sample_z;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                regs[i] <= reg_reset_value(6'(i), DEVID_VALUE);
            end
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
        end else begin
            reg_wr_strobe <= wr_commit;
            if (wr_commit) begin
                regs[cmd.addr] <= rx_byte;
                reg_wr_addr    <= cmd.addr;
                reg_wr_data    <= rx_byte;
            end
            if (load_samples) begin
                regs[ADDR_DATAX0] <= ld_x[7:0];
                regs[ADDR_DATAX1] <= ld_x[15:8];
                regs[ADDR_DATAY0] <= ld_y[7:0];
                regs[ADDR_DATAY1] <= ld_y[15:8];
                regs[ADDR_DATAZ0] <= ld_z[7:0];
                regs[ADDR_DATAZ1] <= ld_z[15:8];
            end
        end
    end

    always_comb begin
        bw_rate     = regs[ADDR_BW_RATE];
        power_ctl   = regs[ADDR_POWER_CTL];
        data_format = regs[ADDR_DATA_FORMAT];
    end

endmodule

// File: tb/tb_adxl345_spi_slave.sv
// Directed bench for adxl345_spi_slave: drives SPI mode-3 transfers and checks bytes, enables and registers.
// Latency: n/a.
// Backpressure: n/a.
module tb_adxl345_spi_slave;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_clk;
    logic        CS;
    logic        MOSI;
    logic        MISO;
    logic        miso_oe;
    logic [15:0] sample_x;
    logic [15:0] sample_y;
    logic [15:0] sample_z;
    logic        sample_valid;
    logic        reg_wr_strobe;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic [7:0]  bw_rate;
    logic [7:0]  power_ctl;
    logic [7:0]  data_format;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  strobe_cnt = 8'd0;
    logic [7:0]  rx;
    logic [7:0]  oe;
    logic [7:0]  exp_b [6];

    adxl345_spi_slave #(
        .SYNC_STAGES (2),
        .DEVID_VALUE (8'hE5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_clk       (spi_clk),
        .CS            (CS),
        .MOSI          (MOSI),
        .MISO          (MISO),
        .miso_oe       (miso_oe),
        .sample_x      (sample_x),
        .sample_y      (sample_y),
        .sample_z      (sample_z),
        .sample_valid  (sample_valid),
        .reg_wr_strobe (reg_wr_strobe),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .bw_rate       (bw_rate),
        .power_ctl     (power_ctl),
        .data_format   (data_format)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_strobe) strobe_cnt <= strobe_cnt + 8'd1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic half_bit();
        repeat (HALF) @(negedge clk);
    endtask

    // Mode 3: drive MOSI on the falling edge, sample MISO on the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx_o, output logic [7:0] oe_o);
        rx_o = 8'hFF;
        oe_o = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            spi_clk = 1'b0;
            MOSI    = tx[7-b];
            half_bit();
            spi_clk = 1'b1;
            rx_o[7-b] = MISO;
            oe_o[7-b] = miso_oe;
            half_bit();
        end
    endtask

    task automatic cs_begin();
        CS = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic cs_end();
        CS   = 1'b1;
        MOSI = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_samples(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sample_x     = x;
        sample_y     = y;
        sample_z     = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        spi_clk      = 1'b1;
        CS           = 1'b1;
        MOSI         = 1'b0;
        sample_x     = '0;
        sample_y     = '0;
        sample_z     = '0;
        sample_valid = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_miso", {7'd0, MISO}, 8'h01);
        check("rst_oe", {7'd0, miso_oe}, 8'h00);
        check("rst_strobe", {7'd0, reg_wr_strobe}, 8'h00);
        check("rst_wr_addr", {2'd0, reg_wr_addr}, 8'h00);
        check("rst_wr_data", reg_wr_data, 8'h00);
        check("rst_bw_rate", bw_rate, 8'h0A);
        check("rst_power_ctl", power_ctl, 8'h00);
        check("rst_data_format", data_format, 8'h00);

        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // DEVID read
        cs_begin();
        spi_bits(8'h80, 8, rx, oe);
        check("devid_cmd_oe", oe, 8'h00);
        spi_bits(8'h00, 8, rx, oe);
        check("devid_data", rx, 8'hE5);
        check("devid_data_oe", oe, 8'hFF);
        cs_end();
        check("devid_after_oe", {7'd0, miso_oe}, 8'h00);
        check("devid_after_miso", {7'd0, MISO}, 8'h01);

        // POWER_CTL write
        cs_begin();
        spi_bits(8'h2D, 8, rx, oe);
        spi_bits(8'h08, 8, rx, oe);
        check("wr_data_oe", oe, 8'h00);
        cs_end();
        check("wr_power_ctl", power_ctl, 8'h08);
        check("wr_strobe_cnt", strobe_cnt, 8'd1);
        check("wr_addr", {2'd0, reg_wr_addr}, 8'h2D);
        check("wr_data", reg_wr_data, 8'h08);

        // Single-byte-address read twice (MB=0)
        cs_begin();
        spi_bits(8'hAC, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        check("bw_rd0", rx, 8'h0A);
        spi_bits(8'h00, 8, rx, oe);
        check("bw_rd1_fixed_addr", rx, 8'h0A);
        cs_end();

        // Axis burst
        pulse_samples(16'h0123, 16'h0456, 16'h0789);
        exp_b = '{8'h23, 8'h01, 8'h56, 8'h04, 8'h89, 8'h07};
        cs_begin();
        spi_bits(8'hF2, 8, rx, oe);
        for (int i = 0; i < 6; i++) begin
            spi_bits(8'h00, 8, rx, oe);
            check($sformatf("burst0_b%0d", i), rx, exp_b[i]);
        end
        cs_end();

        // New samples arrive after two bytes of a burst
`ifdef ADXL345_SLAVE_SNAPSHOT_EN
        exp_b = '{8'h23, 8'h01, 8'h56, 8'h04, 8'h89, 8'h07};
`else
        exp_b = '{8'h23, 8'h01, 8'h56, 8'hC3, 8'hF6, 8'hE5};
`endif
        cs_begin();
        spi_bits(8'hF2, 8, rx, oe);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                @(negedge clk);
                sample_x     = 16'hA1B2;
                sample_y     = 16'hC3D4;
                sample_z     = 16'hE5F6;
                sample_valid = 1'b1;
                @(negedge clk);
                sample_valid = 1'b0;
            end
            spi_bits(8'h00, 8, rx, oe);
            check($sformatf("burst1_b%0d", i), rx, exp_b[i]);
        end
        cs_end();

        exp_b = '{8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hF6, 8'hE5};
        cs_begin();
        spi_bits(8'hF2, 8, rx, oe);
        for (int i = 0; i < 6; i++) begin
            spi_bits(8'h00, 8, rx, oe);
            check($sformatf("burst2_b%0d", i), rx, exp_b[i]);
        end
        cs_end();

        // Aborted write after 4 data bits, then a clean write
        cs_begin();
        spi_bits(8'h31, 8, rx, oe);
        spi_bits(8'hFF, 4, rx, oe);
        cs_end();
        check("partial_data_format", data_format, 8'h00);
        check("partial_strobe_cnt", strobe_cnt, 8'd1);
        cs_begin();
        spi_bits(8'h31, 8, rx, oe);
        spi_bits(8'h0B, 8, rx, oe);
        cs_end();
        check("full_data_format", data_format, 8'h0B);
        check("full_strobe_cnt", strobe_cnt, 8'd2);

        // Read-only targets
        cs_begin();
        spi_bits(8'h00, 8, rx, oe);
        spi_bits(8'h55, 8, rx, oe);
        cs_end();
        cs_begin();
        spi_bits(8'h32, 8, rx, oe);
        spi_bits(8'h77, 8, rx, oe);
        cs_end();
        check("ro_strobe_cnt", strobe_cnt, 8'd2);
        check("ro_wr_addr", {2'd0, reg_wr_addr}, 8'h31);
        cs_begin();
        spi_bits(8'h80, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        cs_end();
        check("ro_devid", rx, 8'hE5);

        // Address wrap 0x3F -> 0x00
        cs_begin();
        spi_bits(8'h3F, 8, rx, oe);
        spi_bits(8'h5A, 8, rx, oe);
        cs_end();
        check("wr3f_strobe_cnt", strobe_cnt, 8'd3);
        cs_begin();
        spi_bits(8'hFF, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        check("wrap_b0", rx, 8'h5A);
        spi_bits(8'h00, 8, rx, oe);
        check("wrap_b1", rx, 8'hE5);
        cs_end();

        // Multi-byte write 0x2C, 0x2D
        cs_begin();
        spi_bits(8'h6C, 8, rx, oe);
        spi_bits(8'h11, 8, rx, oe);
        spi_bits(8'h22, 8, rx, oe);
        cs_end();
        check("mbw_bw_rate", bw_rate, 8'h11);
        check("mbw_power_ctl", power_ctl, 8'h22);
        check("mbw_strobe_cnt", strobe_cnt, 8'd5);
        check("mbw_wr_addr", {2'd0, reg_wr_addr}, 8'h2D);
        check("mbw_wr_data", reg_wr_data, 8'h22);

        // Reset mid-transfer with CS held low across it
        cs_begin();
        spi_bits(8'h80, 4, rx, oe);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_oe", {7'd0, miso_oe}, 8'h00);
        check("midrst_bw_rate", bw_rate, 8'h0A);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        spi_bits(8'h80, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        check("midrst_ignored_rx", rx, 8'hFF);
        check("midrst_ignored_oe", oe, 8'h00);
        cs_end();
        cs_begin();
        spi_bits(8'h80, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        cs_end();
        check("postrst_devid", rx, 8'hE5);
        check("postrst_oe", oe, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adxl345_spi_slave.md
ADXL345_SPI_SLAVE -- requirements
Module: adxl345_spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for spi_clk, CS and MOSI.
REQ-002 SHALL have parameter DEVID_VALUE, default 8'hE5: read-only value of register 0x00.
REQ-003 SHALL have clk input, 1 bit: the single system clock, rising edge.
REQ-004 SHALL have rst_n input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have spi_clk input, 1 bit: SPI clock from the master; mode 3, idles high.
REQ-006 SHALL have CS input, 1 bit: chip select, active-low.
REQ-007 SHALL have MOSI input, 1 bit: serial data from the master, MSB first.
REQ-008 SHALL have MISO output, 1 bit: serial data to the master, MSB first.
REQ-009 SHALL have miso_oe output, 1 bit: MISO drive enable, high only in the read-data phase.
REQ-010 SHALL have sample_x, sample_y and sample_z inputs, 16 bits each: axis samples from the sensor model.
REQ-011 SHALL have sample_valid input, 1 bit: one-cycle strobe that loads the three samples.
REQ-012 SHALL have reg_wr_strobe output, 1 bit: one-cycle pulse per accepted register write.
REQ-013 SHALL have reg_wr_addr output, 6 bits, and reg_wr_data output, 8 bits: address and data of the last accepted write.
REQ-014 SHALL have bw_rate, power_ctl and data_format outputs, 8 bits each: live register contents.

Function
REQ-015 SHALL pass spi_clk, CS and MOSI through SYNC_STAGES flops and detect spi_clk edges on the synchronized copy; clk >= 8x spi_clk.
REQ-016 SHALL use three states: IDLE (CS high), CMD (command bits 0-7), DATA (data bytes until CS rises).
REQ-017 SHALL go from IDLE to CMD on synchronized CS falling, bit counter = 0.
REQ-018 SHALL sample MOSI on each synchronized spi_clk rising edge and shift MISO on each falling edge.
REQ-019 SHALL decode the command byte as bit7 R/W (1 = read), bit6 MB (multi-byte) and bits5:0 address.
REQ-020 SHALL go from CMD to DATA on the 8th rising edge; for a read, it SHALL drive bit7 of reg[addr] on the next falling edge, within SYNC_STAGES+1 clk cycles.
REQ-021 SHALL, when MB=1, post-increment the address after each completed data byte, wrapping 0x3F to 0x00; when MB=0, the address SHALL stay fixed.
REQ-022 SHALL, on a write, commit each full data byte on its 8th rising edge, pulse reg_wr_strobe for 1 cycle and update reg_wr_addr/data.
REQ-023 SHALL ignore writes to read-only addresses 0x00 and 0x32-0x37 (no strobe); unlisted addresses 0x01-0x3F read/write as plain storage.
REQ-024 SHALL map DATAX0..DATAZ1 (0x32-0x37) to sample_x[7:0], sample_x[15:8], sample_y[7:0], sample_y[15:8], sample_z[7:0], sample_z[15:8].
REQ-025 SHALL, on CS rising mid-byte, discard the partial byte, emit no write, deassert miso_oe and enter IDLE within 1 cycle of sync.
REQ-026 SHALL drive MISO = 1 whenever miso_oe = 0.

Reset
REQ-027 SHALL, while rst_n = 0, hold state IDLE, counters 0, MISO = 1, miso_oe = 0, reg_wr_strobe = 0, reg_wr_addr = 0 and reg_wr_data = 0.
REQ-028 SHALL reset register values to 0x00 = DEVID_VALUE, bw_rate 0x2C = 8'h0A, power_ctl 0x2D = 8'h00, data_format 0x31 = 8'h00, others 0, samples 0.
REQ-029 SHALL, on reset mid-transfer, abort the transfer; after release, the block SHALL wait for CS high then low before decoding.

Configuration
REQ-030 SHALL, with macro ADXL345_SLAVE_SNAPSHOT_EN defined, load sample_valid into a shadow set and copy it into 0x32-0x37 only while in IDLE, so a burst read is coherent.
REQ-031 SHALL, without ADXL345_SLAVE_SNAPSHOT_EN, load 0x32-0x37 directly on sample_valid at any time.

Structure
REQ-032 SHALL take register address constants, reset values and the state enum from shared package adxl345_pkg.
REQ-033 SHALL place the synchronizer and edge detector in sub-module spi_sync_edge.

Verification
REQ-034 Read 0x00 (cmd 8'h80) SHALL return MISO byte 8'hE5, with miso_oe high only for the data byte.
REQ-035 Write 8'h2D/8'h08 SHALL give power_ctl = 8'h08 and a single reg_wr_strobe with addr 0x2D, data 0x08.
REQ-036 sample_x=16'h0123, y=16'h0456, z=16'h0789, then read 8'hF2 for 6 bytes, SHALL return 23 01 56 04 89 07.
REQ-037 With the macro, sample_valid mid-burst SHALL leave the burst with old values; the next burst SHALL return new values.
REQ-038 CS raised after 4 bits of data on write 8'h31 SHALL leave data_format = 8'h00 with no strobe; write 8'h00/8'h55 SHALL leave DEVID 8'hE5.
REQ-039 MB read starting at 0x3F for 2 bytes SHALL return reg[0x3F] then 8'hE5.
